// File: rtl/validator_pkg.sv
// Shared types and constants for the validator scheduler and its arbiter.
// Holds the FSM state encoding, default transaction width and counter widths.
package validator_pkg;

    localparam int DATA_W_DEF = 128;
    localparam int THR_W      = 4;
    localparam int STAT_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_THROTTLE
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first valid requester after last_id.
// Latency: combinational, 0 cycles.
// Backpressure: none; the caller decides whether the grant is taken.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_id,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       grant_vld
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_vld = 1'b0;
        sum       = '0;
        idx       = '0;
        // Scan from last_id+1 upward, wrapping, so the previous winner is checked last.
        for (int i = 1; i <= NUM_REQ; i++) begin
            sum = {1'b0, last_id} + (ID_W+1)'(i);
            if (sum >= (ID_W+1)'(NUM_REQ))
                sum = sum - (ID_W+1)'(NUM_REQ);
            idx = sum[ID_W-1:0];
            if (!grant_vld && req[idx]) begin
                grant_vld  = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = idx;
            end
        end
    end

endmodule

// File: rtl/validator_scheduler.sv
// Round-robin scheduler feeding one transaction per issue to the validator; optional stats via VALIDATOR_SCHED_STATS_EN.
// Latency: 1 cycle from handshake to o_valid; GAP idle cycles forced after each issue.
// Backpressure: o_req_ready only in ISSUE with i_enable high; o_valid is not backpressured.
module validator_scheduler
    import validator_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int GAP     = 0,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_enable,
    input  logic [NUM_REQ-1:0]          i_req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   i_req_data,
    output logic [NUM_REQ-1:0]          o_req_ready,
    output logic                        o_valid,
    output logic [DATA_W-1:0]           o_transaction,
    output logic [$clog2(NUM_REQ)-1:0]  o_req_id,
`ifdef VALIDATOR_SCHED_STATS_EN
    output logic [NUM_REQ*STAT_W-1:0]   o_issue_cnt,
`endif
    output logic                        o_busy
);
    localparam int ID_W = $clog2(NUM_REQ);

    sched_state_t       state;
    logic [THR_W-1:0]   thr_cnt;
    logic [ID_W-1:0]    last_id;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               grant_vld;
    logic               issue_ok;
    logic               fire;
    logic               any_req;
    logic [DATA_W-1:0]  sel_data;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req       (i_req_valid),
        .last_id   (last_id),
        .grant     (grant),
        .grant_id  (grant_id),
        .grant_vld (grant_vld)
    );

    assign any_req     = |i_req_valid;
    assign issue_ok    = (state == ST_ISSUE) && i_enable;
    assign fire        = issue_ok && grant_vld;
    assign o_req_ready = issue_ok ? grant : '0;
    assign o_busy      = (state != ST_IDLE);

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NUM_REQ; k++)
            if (grant[k])
                sel_data = i_req_data[k*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            thr_cnt       <= '0;
            last_id       <= ID_W'(NUM_REQ-1);
            o_valid       <= 1'b0;
            o_transaction <= '0;
            o_req_id      <= '0;
        end else begin
            o_valid <= fire;
            if (fire) begin
                o_transaction <= sel_data;
                o_req_id      <= grant_id;
                last_id       <= grant_id;
            end
            case (state)
                ST_IDLE: begin
                    if (i_enable && any_req)
                        state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    // No handshake covers both enable dropping and every requester withdrawing.
                    if (!fire)
                        state <= ST_IDLE;
                    else if (GAP == 0)
                        state <= ST_ISSUE;
                    else begin
                        state   <= ST_THROTTLE;
                        thr_cnt <= THR_W'(GAP);
                    end
                end
                ST_THROTTLE: begin
                    thr_cnt <= thr_cnt - 1'b1;
                    if (thr_cnt == THR_W'(1))
                        state <= (i_enable && any_req) ? ST_ISSUE : ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef VALIDATOR_SCHED_STATS_EN
    logic [STAT_W-1:0] issue_cnt [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_stats
        always_ff @(posedge clk or negedge rst) begin
            if (!rst)
                issue_cnt[k] <= '0;
            else if (fire && grant[k] && (issue_cnt[k] != '1))
                issue_cnt[k] <= issue_cnt[k] + 1'b1;
        end
        assign o_issue_cnt[k*STAT_W +: STAT_W] = issue_cnt[k];
    end
`endif

endmodule

// File: tb/tb_validator_scheduler.sv
// Scoreboard bench: instance 0 runs GAP=0, instance 1 runs GAP=2; stimulus pushes
// expected issues, a negedge monitor pops and compares them one cycle later.
`timescale 1ns/1ps
module tb_validator_scheduler;
    localparam int N  = 4;
    localparam int DW = 128;

    typedef struct {
        int          id;
        logic [DW-1:0] d;
        int          cyc;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            en  [2];
    logic [N-1:0]    vld [2];
    logic [DW-1:0]   dat [N];
    logic [N*DW-1:0] bus;
    logic [N-1:0]    rdy [2];
    logic            ov  [2];
    logic [DW-1:0]   tx  [2];
    logic [1:0]      id  [2];
    logic            busy[2];
`ifdef VALIDATOR_SCHED_STATS_EN
    logic [N*16-1:0] icnt[2];
    int              exp_cnt[2][N];
`endif

    exp_t q0[$];
    exp_t q1[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc_n = 0;
    bit   discard = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    for (genvar k = 0; k < N; k++) begin : g_bus
        assign bus[k*DW +: DW] = dat[k];
    end

    validator_scheduler #(.NUM_REQ(N), .GAP(0), .DATA_W(DW)) dut0 (
        .clk(clk), .rst(rst), .i_enable(en[0]), .i_req_valid(vld[0]), .i_req_data(bus),
        .o_req_ready(rdy[0]), .o_valid(ov[0]), .o_transaction(tx[0]), .o_req_id(id[0]),
`ifdef VALIDATOR_SCHED_STATS_EN
        .o_issue_cnt(icnt[0]),
`endif
        .o_busy(busy[0]));

    validator_scheduler #(.NUM_REQ(N), .GAP(2), .DATA_W(DW)) dut1 (
        .clk(clk), .rst(rst), .i_enable(en[1]), .i_req_valid(vld[1]), .i_req_data(bus),
        .o_req_ready(rdy[1]), .o_valid(ov[1]), .o_transaction(tx[1]), .o_req_id(id[1]),
`ifdef VALIDATOR_SCHED_STATS_EN
        .o_issue_cnt(icnt[1]),
`endif
        .o_busy(busy[1]));

    function automatic void chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endfunction

    function automatic void mon(input int s, input logic v, input logic [1:0] i, input logic [DW-1:0] d);
        exp_t e;
        bit   have;
        if (s == 0) have = (q0.size() > 0) && (q0[0].cyc < cyc_n);
        else        have = (q1.size() > 0) && (q1[0].cyc < cyc_n);
        if (have) begin
            if (s == 0) e = q0.pop_front();
            else        e = q1.pop_front();
        end
        if (v && !have) begin
            n_cmp++; n_bad++;
            $display("FAIL mon%0d_unexpected: o_valid=1 id=%0d, expected no issue", s, i);
        end else if (!v && have) begin
            n_cmp++; n_bad++;
            $display("FAIL mon%0d_missing: o_valid=0, expected issue id=%0d", s, e.id);
        end else if (v) begin
            chk($sformatf("mon%0d_id", s), DW'(i), DW'(e.id));
            chk($sformatf("mon%0d_data", s), d, e.d);
        end
    endfunction

    always @(negedge clk) begin
        mon(0, ov[0], id[0], tx[0]);
        mon(1, ov[1], id[1], tx[1]);
    end

    // Called at posedge+1; checks mid-cycle, then advances to the next posedge+1.
    task automatic cyc(input int s, input logic [N-1:0] er, input logic eb, input string nm);
        exp_t e;
        #3;
        chk({nm, "_rdy"}, DW'(rdy[s]), DW'(er));
        chk({nm, "_busy"}, DW'(busy[s]), DW'(eb));
        if (er != '0 && !discard) begin
            for (int k = 0; k < N; k++)
                if (er[k]) begin
                    e.id  = k;
                    e.d   = dat[k];
                    e.cyc = cyc_n;
`ifdef VALIDATOR_SCHED_STATS_EN
                    if (exp_cnt[s][k] < 65535) exp_cnt[s][k]++;
`endif
                end
            if (s == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
`ifdef VALIDATOR_SCHED_STATS_EN
        for (int s = 0; s < 2; s++)
            for (int k = 0; k < N; k++)
                exp_cnt[s][k] = 0;
`endif
    endtask

    initial begin
        rst = 1'b0;
        clear_model();
        for (int s = 0; s < 2; s++) begin en[s] = 1'b1; vld[s] = '1; end
        for (int k = 0; k < N; k++) dat[k] = DW'(8'hA0 + k);
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("rst%0d_valid", s), DW'(ov[s]), '0);
            chk($sformatf("rst%0d_trans", s), tx[s], '0);
            chk($sformatf("rst%0d_id", s), DW'(id[s]), '0);
            chk($sformatf("rst%0d_rdy", s), DW'(rdy[s]), '0);
            chk($sformatf("rst%0d_busy", s), DW'(busy[s]), '0);
        end
        rst = 1'b1;
        en[1] = 1'b0; vld[1] = '0;

        // GAP=0 strict rotation over all four requesters
        cyc(0, 4'b0000, 0, "rot_idle");
        for (int i = 0; i < 5; i++) cyc(0, 4'(1 << (i % 4)), 1, "rot");
        vld[0] = '0;
        cyc(0, 4'b0000, 1, "rot_drain");
        cyc(0, 4'b0000, 0, "rot_done");

        // enable dropped right after a grant to requester 2
        vld[0] = 4'b0100;
        cyc(0, 4'b0000, 0, "en_idle");
        cyc(0, 4'b0100, 1, "en_g2");
        en[0] = 1'b0; vld[0] = '1;
        cyc(0, 4'b0000, 1, "en_off");
        cyc(0, 4'b0000, 0, "en_off_idle");
        cyc(0, 4'b0000, 0, "en_off_idle2");
        en[0] = 1'b1;
        cyc(0, 4'b0000, 0, "en_back");
        cyc(0, 4'b1000, 1, "en_g3");
        vld[0] = '0;
        cyc(0, 4'b0000, 1, "en_drain");
        cyc(0, 4'b0000, 0, "en_done");

        // withdrawn request must not move the pointer
        vld[0] = 4'b0001;
        cyc(0, 4'b0000, 0, "wd_idle");
        cyc(0, 4'b0001, 1, "wd_g0");
        vld[0] = 4'b0000;
        cyc(0, 4'b0000, 1, "wd_drain");
        vld[0] = 4'b0010;
        cyc(0, 4'b0000, 0, "wd_idle2");
        vld[0] = 4'b0000;
        cyc(0, 4'b0000, 1, "wd_drop");
        vld[0] = 4'b1111;
        cyc(0, 4'b0000, 0, "wd_idle3");
        cyc(0, 4'b0010, 1, "wd_g1");
        vld[0] = '0;
        cyc(0, 4'b0000, 1, "wd_drain2");
        cyc(0, 4'b0000, 0, "wd_done");

        // reset in the middle of an issue discards the registered transaction
        vld[0] = '1;
        cyc(0, 4'b0000, 0, "mr_idle");
        discard = 1'b1;
        cyc(0, 4'b0100, 1, "mr_g2");
        discard = 1'b0;
        rst = 1'b0;
        clear_model();
        #3;
        chk("mr_valid_in_rst", DW'(ov[0]), '0);
        chk("mr_trans_in_rst", tx[0], '0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        #3;
        chk("mr_valid_after", DW'(ov[0]), '0);
        @(posedge clk); #1;
        cyc(0, 4'b0001, 1, "mr_g0");
        vld[0] = '0;
        cyc(0, 4'b0000, 1, "mr_drain");
        cyc(0, 4'b0000, 0, "mr_done");

        // requester 0 alone, five back-to-back issues with changing data
        vld[0] = 4'b0001;
        cyc(0, 4'b0000, 0, "r0_idle");
        for (int i = 0; i < 5; i++) begin
            dat[0] = DW'(128'h5A5A_0000_0000_0000_0000_0000_0000_1000) + DW'(i);
            cyc(0, 4'b0001, 1, "r0");
        end
        vld[0] = '0;
        cyc(0, 4'b0000, 1, "r0_drain");
        cyc(0, 4'b0000, 0, "r0_done");
`ifdef VALIDATOR_SCHED_STATS_EN
        chk("cnt_r0", DW'(icnt[0][15:0]), DW'(exp_cnt[0][0]));
        chk("cnt_r2", DW'(icnt[0][47:32]), DW'(exp_cnt[0][2]));
`endif

        // GAP=2, requesters 1 and 3
        en[1] = 1'b1; vld[1] = 4'b1010;
        cyc(1, 4'b0000, 0, "gap_idle");
        cyc(1, 4'b0010, 1, "gap_g1");
        cyc(1, 4'b0000, 1, "gap_thr");
        cyc(1, 4'b0000, 1, "gap_thr");
        cyc(1, 4'b1000, 1, "gap_g3");
        cyc(1, 4'b0000, 1, "gap_thr");
        cyc(1, 4'b0000, 1, "gap_thr");
        cyc(1, 4'b0010, 1, "gap_g1b");
        vld[1] = '0;
        cyc(1, 4'b0000, 1, "gap_thr_end");
        cyc(1, 4'b0000, 1, "gap_thr_end");
        cyc(1, 4'b0000, 0, "gap_done");

        // enable dropped during throttle: gap still runs to completion
        vld[1] = 4'b0100;
        cyc(1, 4'b0000, 0, "gt_idle");
        cyc(1, 4'b0100, 1, "gt_g2");
        en[1] = 1'b0;
        cyc(1, 4'b0000, 1, "gt_thr");
        cyc(1, 4'b0000, 1, "gt_thr");
        cyc(1, 4'b0000, 0, "gt_idle_off");
        en[1] = 1'b1;
        cyc(1, 4'b0000, 0, "gt_back");
        cyc(1, 4'b0100, 1, "gt_g2b");
        vld[1] = '0;
        cyc(1, 4'b0000, 1, "gt_thr2");
        cyc(1, 4'b0000, 1, "gt_thr2");
        cyc(1, 4'b0000, 0, "gt_done");

`ifdef VALIDATOR_SCHED_STATS_EN
        vld[0] = 4'b0001;
        cyc(0, 4'b0000, 0, "sat_idle");
        for (int i = 0; i < 65540; i++) cyc(0, 4'b0001, 1, "sat");
        vld[0] = '0;
        cyc(0, 4'b0000, 1, "sat_drain");
        chk("cnt_sat", DW'(icnt[0][15:0]), DW'(16'hFFFF));
        chk("cnt_sat_model", DW'(exp_cnt[0][0]), DW'(65535));
`endif

        repeat (2) @(posedge clk);
        #3;
        chk("queue_empty", DW'(q0.size() + q1.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/validator_scheduler.md
VALIDATOR_SCHEDULER -- requirements
Module: validator_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4, number of transaction requesters; legal range 2..8.
REQ-002 Parameter GAP, default 0, number of idle cycles forced after each issue; legal range 0..15.
REQ-003 Parameter DATA_W, default 128, transaction width.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 i_enable  in  1  scheduler enable; when low, no new grants.
REQ-007 i_req_valid  in  NUM_REQ  per-requester transaction valid.
REQ-008 i_req_data  in  NUM_REQ*DATA_W  per-requester transaction, requester k at bits [k*DATA_W +: DATA_W].
REQ-009 o_req_ready  out  NUM_REQ  one-hot accept strobe; a transfer occurs when valid and ready are both high.
REQ-010 o_valid  out  1  registered transaction valid toward validator i_valid.
REQ-011 o_transaction  out  DATA_W  registered transaction toward validator i_transcation.
REQ-012 o_req_id  out  clog2(NUM_REQ)  index of the requester that sourced o_transaction.
REQ-013 o_busy  out  1  high when the FSM is not in IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, ISSUE, THROTTLE.
REQ-015 IDLE -> ISSUE when i_enable is high and any i_req_valid is high; otherwise stay IDLE.
REQ-016 In ISSUE, exactly one o_req_ready bit SHALL be high, selected combinationally by round-robin among valid requesters.
REQ-017 Round-robin priority SHALL start at the index one above the last granted requester and wrap from NUM_REQ-1 to 0; after reset the last-granted index is NUM_REQ-1, so requester 0 has priority.
REQ-018 The accepted transaction SHALL appear on o_transaction with o_valid high for exactly one cycle, one clock after the handshake; latency is 1 cycle.
REQ-019 After an issue: GAP=0 -> stay ISSUE if any request is valid and i_enable is high, else IDLE; GAP>0 -> THROTTLE.
REQ-020 THROTTLE SHALL last exactly GAP cycles via a down-counter, then go to ISSUE if requests are pending and i_enable is high, else IDLE.
REQ-021 o_req_ready SHALL be all-zero in IDLE and THROTTLE, and whenever i_enable is low.
REQ-022 i_enable falling in ISSUE SHALL return the FSM to IDLE next cycle with no grant; a GAP in progress completes regardless.
REQ-023 A requester dropping valid before it is granted SHALL lose no other requester's turn, and the pointer SHALL NOT advance.
REQ-024 o_transaction and o_req_id SHALL hold their last values when o_valid is low.
REQ-025 At GAP=0 with all requesters continuously valid, throughput SHALL be one issue per cycle in strict rotation.

Reset
REQ-026 On rst low: FSM=IDLE, o_valid=0, o_transaction=0, o_req_id=0, o_req_ready=0, o_busy=0, throttle counter=0, last-granted index=NUM_REQ-1.
REQ-027 Reset asserted mid-issue SHALL discard the registered transaction; o_valid SHALL be 0 on the cycle after release.

Configuration
REQ-028 Macro VALIDATOR_SCHED_STATS_EN: when defined, adds output o_issue_cnt (NUM_REQ*16) with one saturating 16-bit issue counter per requester, reset to 0; when undefined, the port and counters are absent and behaviour is otherwise identical.

Structure
REQ-029 Package validator_pkg SHALL hold the FSM state enum, the DATA_W default, and the counter width constant.
REQ-030 Sub-module rr_arbiter (request vector plus last-granted index in, one-hot grant plus encoded index out, combinational) SHALL be the only sub-module.

Verification
REQ-031 Reset: rst low for 3 cycles with all valid high -> all outputs 0, o_req_ready=0.
REQ-032 GAP=0, requesters 0..3 continuously valid, data 0xA0..0xA3 -> o_valid high every cycle, o_req_id sequence 0,1,2,3,0, data matching.
REQ-033 GAP=2, requesters 1 and 3 valid -> grants 1,3,1 spaced 3 cycles apart; o_busy high throughout.
REQ-034 i_enable dropped in the cycle after a grant to requester 2 -> no further o_req_ready; FSM in IDLE; when re-enabled, the next grant goes to requester 3 if it is valid.
REQ-035 Requester 0 only, valid for 5 cycles with GAP=0 -> five issues, id 0 each; counter reads 5 with VALIDATOR_SCHED_STATS_EN.
REQ-036 Counter saturation with VALIDATOR_SCHED_STATS_EN: preload near 0xFFFF, then issue 3 more -> counter holds at 0xFFFF.
